// File: rtl/multi_stopwatch_core.sv
// Multi-channel BCD stopwatch with per-channel run/pause/split control and a circular
// stash of captured readings. Each channel counts 00..99 on a shared one-second tick.
//
//   state   | meaning
//   IDLE    | cleared, not counting
//   RUN     | counting, display follows count
//   PAUSE   | stopped, display follows (frozen) count
//   SPLIT   | counting, display frozen at split entry
module multi_stopwatch_core #(
   parameter int CHANNELS    = 2,
   parameter int CLK_FREQ    = 100000000,
   parameter int STASH_DEPTH = 5,
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int CNTW = $clog2(STASH_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                trig,
   input  logic                split,
   input  logic                clr_ch,
   input  logic                toggle,
   input  logic                sample,
   input  logic                next_sample,
   output logic [SELW-1:0]     sel,
   output logic [CHANNELS-1:0] sel_onehot,
   output logic [CHANNELS-1:0] run_mask,
   output logic [15:0]         time_reading,
   output logic [SELW-1:0]     stash_ch,
   output logic [CNTW-1:0]     stash_count
);

   localparam int PSW = $clog2(CLK_FREQ);
   localparam int PW  = $clog2(STASH_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_SPLIT} ch_state_t;

   logic [PSW-1:0] ps_q;
   logic           tick;
   logic [SELW-1:0] sel_q;

   ch_state_t  st_q   [CHANNELS];
   ch_state_t  st_d   [CHANNELS];
   logic [7:0] cnt_q  [CHANNELS];
   logic [7:0] cnt_d  [CHANNELS];
   logic [7:0] disp_q [CHANNELS];
   logic [7:0] disp_d [CHANNELS];

   logic [SELW+7:0] mem_q [STASH_DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, oldest;
   logic [CNTW-1:0] sc_q, sc_d;
   logic [SELW+7:0] entry;
   int              oldest_i;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] t, o;
      t = v[7:4];
      o = v[3:0];
      if (o >= 4'd9) begin
         o = 4'd0;
         t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
         o = o + 4'd1;
      end
      return {t, o};
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(STASH_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? PW'(STASH_DEPTH - 1) : p - 1'b1;
   endfunction

   assign tick = (ps_q == PSW'(CLK_FREQ - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_q  <= '0;
         sel_q <= '0;
      end else begin
         ps_q <= tick ? '0 : ps_q + 1'b1;
         if (toggle)
            sel_q <= (sel_q == SELW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
      end
   end

   // Commands act on sel_q, i.e. the selection before any same-cycle toggle.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         if (tick && (st_q[i] == S_RUN || st_q[i] == S_SPLIT))
            cnt_d[i] = bcd_inc(cnt_q[i]);
         if (sel_q == SELW'(i)) begin
            if (clr_ch) begin
               st_d[i]  = S_IDLE;
               cnt_d[i] = 8'h00;
            end else if (trig) begin
               case (st_q[i])
                  S_IDLE:  st_d[i] = S_RUN;
                  S_RUN:   st_d[i] = S_PAUSE;
                  S_PAUSE: st_d[i] = S_RUN;
                  S_SPLIT: st_d[i] = S_PAUSE;
                  default: st_d[i] = S_IDLE;
               endcase
            end else if (split) begin
               if (st_q[i] == S_RUN)        st_d[i] = S_SPLIT;
               else if (st_q[i] == S_SPLIT) st_d[i] = S_RUN;
            end
         end
         disp_d[i] = (st_q[i] == S_SPLIT && st_d[i] == S_SPLIT) ? disp_q[i] : cnt_d[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (reset) begin
            st_q[i]   <= S_IDLE;
            cnt_q[i]  <= 8'h00;
            disp_q[i] <= 8'h00;
         end else begin
            st_q[i]   <= st_d[i];
            cnt_q[i]  <= cnt_d[i];
            disp_q[i] <= disp_d[i];
         end
      end
   end

   always_comb begin
      oldest_i = int'(wr_q) + STASH_DEPTH - int'(sc_q);
      if (oldest_i >= STASH_DEPTH)
         oldest_i = oldest_i - STASH_DEPTH;
      oldest = PW'(oldest_i);
   end

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      sc_d = sc_q;
      if (sample) begin
         rd_d = wr_q;
         wr_d = ptr_inc(wr_q);
         if (sc_q != CNTW'(STASH_DEPTH))
            sc_d = sc_q + 1'b1;
      end else if (next_sample && sc_q != '0) begin
         rd_d = (rd_q == oldest) ? ptr_dec(wr_q) : ptr_dec(rd_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         sc_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         sc_q <= sc_d;
      end
   end

   // Entry storage needs no reset: stash_count gates every read.
   always_ff @(posedge clk) begin
      if (!reset && sample)
         mem_q[wr_q] <= {sel_q, disp_q[sel_q]};
   end

   assign entry = mem_q[rd_q];

   always_comb begin
      for (int i = 0; i < CHANNELS; i++)
         run_mask[i] = (st_q[i] == S_RUN) || (st_q[i] == S_SPLIT);
   end

   assign sel          = sel_q;
   assign sel_onehot   = CHANNELS'(1) << sel_q;
   assign stash_count  = sc_q;
   assign stash_ch     = (sc_q == '0) ? '0 : entry[SELW+7:8];
   assign time_reading = {disp_q[sel_q], (sc_q == '0) ? 8'h00 : entry[7:0]};

endmodule

// File: tb/tb_multi_stopwatch_core.sv
// Bench for multi_stopwatch_core: directed scenarios plus random pulses, checked against
// a cycle-level behavioural model built from integers and queues.
module tb_multi_stopwatch_core;
   localparam int CH = 3;
   localparam int F  = 4;
   localparam int D  = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SPLIT = 3;

   logic clk = 1'b0;
   logic reset = 1'b0, trig = 1'b0, split = 1'b0, clr_ch = 1'b0;
   logic toggle = 1'b0, sample = 1'b0, next_sample = 1'b0;
   logic [1:0]  sel, stash_ch, stash_count;
   logic [2:0]  sel_onehot, run_mask;
   logic [15:0] time_reading;

   multi_stopwatch_core #(.CHANNELS(CH), .CLK_FREQ(F), .STASH_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .trig(trig), .split(split), .clr_ch(clr_ch),
      .toggle(toggle), .sample(sample), .next_sample(next_sample),
      .sel(sel), .sel_onehot(sel_onehot), .run_mask(run_mask),
      .time_reading(time_reading), .stash_ch(stash_ch), .stash_count(stash_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_pc, m_sel, m_age;
   int m_st [CH];
   int m_cnt[CH];
   int m_disp[CH];
   int q_ch[$];
   int q_val[$];

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, t, s, c, tg, sm, ns);
      bit tick;
      int osel, prev;
      if (r) begin
         m_pc = 0; m_sel = 0; m_age = 0;
         for (int i = 0; i < CH; i++) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_disp[i] = 0;
         end
         q_ch.delete();
         q_val.delete();
         return;
      end
      tick = (m_pc == F - 1);
      m_pc = (m_pc + 1) % F;
      osel = m_sel;
      if (sm) begin
         q_ch.push_back(osel);
         q_val.push_back(m_disp[osel]);
         if (q_ch.size() > D) begin
            void'(q_ch.pop_front());
            void'(q_val.pop_front());
         end
         m_age = 0;
      end else if (ns && q_ch.size() > 0) begin
         m_age = (m_age + 1) % q_ch.size();
      end
      for (int i = 0; i < CH; i++) begin
         prev = m_st[i];
         if (tick && (prev == M_RUN || prev == M_SPLIT))
            m_cnt[i] = (m_cnt[i] + 1) % 100;
         if (i == osel) begin
            if (c) begin
               m_st[i] = M_IDLE; m_cnt[i] = 0;
            end else if (t) begin
               m_st[i] = (prev == M_RUN || prev == M_SPLIT) ? M_PAUSE : M_RUN;
            end else if (s) begin
               if (prev == M_RUN)        m_st[i] = M_SPLIT;
               else if (prev == M_SPLIT) m_st[i] = M_RUN;
            end
         end
         if (!(prev == M_SPLIT && m_st[i] == M_SPLIT))
            m_disp[i] = m_cnt[i];
      end
      if (tg)
         m_sel = (m_sel + 1) % CH;
   endtask

   task automatic check_all();
      logic [2:0] exp_run;
      logic [7:0] exp_stash;
      logic [1:0] exp_ch;
      exp_run = '0;
      for (int i = 0; i < CH; i++)
         exp_run[i] = (m_st[i] == M_RUN || m_st[i] == M_SPLIT);
      exp_stash = 8'h00;
      exp_ch = 2'd0;
      if (q_ch.size() > 0) begin
         exp_stash = bcd(q_val[q_ch.size() - 1 - m_age]);
         exp_ch = 2'(q_ch[q_ch.size() - 1 - m_age]);
      end
      chk("sel", 16'(sel), 16'(m_sel));
      chk("sel_onehot", 16'(sel_onehot), 16'(1 << m_sel));
      chk("run_mask", 16'(run_mask), 16'(exp_run));
      chk("stash_count", 16'(stash_count), 16'(q_ch.size()));
      chk("stash_ch", 16'(stash_ch), 16'(exp_ch));
      chk("time_reading", time_reading, {bcd(m_disp[m_sel]), exp_stash});
   endtask

   task automatic step(input bit r, t, s, c, tg, sm, ns);
      reset = r; trig = t; split = s; clr_ch = c;
      toggle = tg; sample = sm; next_sample = ns;
      @(posedge clk);
      model_step(r, t, s, c, tg, sm, ns);
      #1;
      reset = 0; trig = 0; split = 0; clr_ch = 0;
      toggle = 0; sample = 0; next_sample = 0;
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_until_cnt0(input int target);
      int n;
      n = 0;
      while (m_cnt[0] != target && n < 1000) begin
         idle();
         n++;
      end
      checks++;
      assert (n < 1000) else begin
         errors++;
         $error("FAIL wait_cnt0 observed=%0d expected=%0d", m_cnt[0], target);
      end
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("rst_reading", time_reading, 16'h0000);
      chk("rst_onehot", 16'(sel_onehot), 16'h0001);

      // 40 cycles of running from reset is exactly ten ticks.
      step(0, 1, 0, 0, 0, 0, 0);
      repeat (40) idle();
      chk("run40_display", 16'(time_reading[15:8]), 16'h0010);
      chk("run40_mask", 16'(run_mask), 16'h0001);

      run_until_cnt0(99);
      run_until_cnt0(0);
      chk("wrap_display", 16'(time_reading[15:8]), 16'h0000);
      chk("wrap_running", 16'(run_mask[0]), 16'h0001);

      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      run_until_cnt0(5);
      step(0, 0, 1, 0, 0, 0, 0);
      repeat (12) idle();
      chk("split_hold", 16'(time_reading[15:8]), 16'h0005);
      chk("split_running", 16'(run_mask[0]), 16'h0001);
      step(0, 0, 1, 0, 0, 0, 0);
      chk("split_release", 16'(time_reading[15:8]), 16'h0008);

      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("toggle1", 16'(sel), 16'd1);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("toggle2", 16'(sel), 16'd2);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("toggle3", 16'(sel), 16'd0);
      step(0, 1, 0, 0, 1, 0, 0);
      chk("trig_toggle_sel", 16'(sel), 16'd1);
      chk("trig_toggle_mask", 16'(run_mask), 16'h0001);

      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      for (int v = 1; v <= 4; v++) begin
         run_until_cnt0(v);
         step(0, 0, 0, 0, 0, 1, 0);
      end
      chk("stash_full", 16'(stash_count), 16'd3);
      chk("stash_newest", 16'(time_reading[7:0]), 16'h0004);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("stash_next1", 16'(time_reading[7:0]), 16'h0003);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("stash_next2", 16'(time_reading[7:0]), 16'h0002);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("stash_next3", 16'(time_reading[7:0]), 16'h0004);

      step(0, 0, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 1, 1);
      chk("rst_sel", 16'(sel), 16'd0);
      chk("rst_onehot2", 16'(sel_onehot), 16'h0001);
      chk("rst_mask", 16'(run_mask), 16'h0000);
      chk("rst_reading2", time_reading, 16'h0000);
      chk("rst_stash_ch", 16'(stash_ch), 16'd0);
      chk("rst_stash_count", 16'(stash_count), 16'd0);

      for (int k = 0; k < 800; k++) begin
         step($urandom_range(99) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
              $urandom_range(29) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0,
              $urandom_range(3) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_stopwatch_core.md
MULTI_STOPWATCH_CORE -- requirements
Module: multi_stopwatch_core

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent stopwatch channels (legal 2..4).
REQ-002 SHALL have parameter CLK_FREQ, default 100000000, clk cycles per one-second tick (legal >=2).
REQ-003 SHALL have parameter STASH_DEPTH, default 5, number of stash entries (legal 2..16).
REQ-004 SHALL define SELW = max(1, clog2(CHANNELS)) and CNTW = clog2(STASH_DEPTH+1) as derived localparams.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 trig  input  1  debounced one-cycle pulse; start/stop of the selected channel.
REQ-008 split  input  1  debounced one-cycle pulse; freeze/unfreeze of the selected channel's display.
REQ-009 clr_ch  input  1  debounced one-cycle pulse; clear the selected channel only.
REQ-010 toggle  input  1  debounced one-cycle pulse; advance channel selection.
REQ-011 sample  input  1  debounced one-cycle pulse; push selected channel's displayed time into stash.
REQ-012 next_sample  input  1  debounced one-cycle pulse; step stash read position.
REQ-013 sel  output  SELW  index of selected channel.
REQ-014 sel_onehot  output  CHANNELS  one-hot of sel, for LEDs.
REQ-015 run_mask  output  CHANNELS  bit i high while channel i is counting (RUN or SPLIT).
REQ-016 time_reading  output  16  {selected channel displayed BCD [15:8], stash_out BCD [7:0]}.
REQ-017 stash_ch  output  SELW  channel index stored with the entry currently shown.
REQ-018 stash_count  output  CNTW  number of valid stash entries.

Function
REQ-019 SHALL contain one free-running prescaler counting 0..CLK_FREQ-1, asserting a one-cycle tick when at CLK_FREQ-1, then wrapping to 0.
REQ-020 Each channel SHALL hold an FSM with states IDLE, RUN, PAUSE, SPLIT, plus an 8-bit BCD count (00..99) and an 8-bit BCD display latch.
REQ-021 FSM transitions on trig: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, SPLIT->PAUSE (display unfreezes).
REQ-022 FSM transitions on split: RUN->SPLIT (latch holds count), SPLIT->RUN; split ignored in IDLE and PAUSE.
REQ-023 Count SHALL increment by one BCD step on tick in RUN or SPLIT; 09->10, 99->00 wrap; ones digit never exceeds 9.
REQ-024 Display latch SHALL track count every cycle except in SPLIT, where it holds the value at SPLIT entry.
REQ-025 clr_ch SHALL force the selected channel to IDLE with count and latch 00 on the next edge, overriding trig/split that cycle.
REQ-026 trig, split, clr_ch, sample SHALL act on the channel selected before any same-cycle toggle.
REQ-027 toggle SHALL set sel to (sel+1) mod CHANNELS; unselected channels continue counting unaffected.
REQ-028 Stash SHALL be a circular buffer of STASH_DEPTH entries of {channel index, 8-bit BCD}.
REQ-029 sample SHALL write the selected channel's display latch at the write pointer, advance it with wrap, increment stash_count saturating at STASH_DEPTH; when full, the oldest entry is overwritten.
REQ-030 After every write, the read position SHALL point to the newest entry.
REQ-031 next_sample SHALL move the read position to the next older valid entry, wrapping from oldest to newest; ignored when stash_count=0.
REQ-032 When sample and next_sample coincide, sample SHALL take effect and next_sample SHALL be ignored.
REQ-033 With stash_count=0, stash_out byte SHALL read 00 and stash_ch 0.
REQ-034 All outputs SHALL be registered or derived from registers only (no input-to-output combinational path); state changes visible one cycle after the input pulse.

Reset
REQ-035 reset SHALL clear prescaler, all channels to IDLE with count/latch 00, sel=0, sel_onehot=1, run_mask=0, stash pointers and stash_count=0, time_reading=0000, stash_ch=0.
REQ-036 reset SHALL override every other input in the same cycle, including mid-count and mid-split.

Verification (CLK_FREQ=4, CHANNELS=3, STASH_DEPTH=3)
REQ-037 reset; trig; wait 40 cycles -> time_reading[15:8]=10, run_mask=001.
REQ-038 Ch0 at 99, next tick -> 00, channel stays RUN.
REQ-039 Ch0 RUN at 05; split; 12 cycles -> display 05 while run_mask[0]=1; split -> display 08.
REQ-040 toggle x3 -> sel 1,2,0; trig+toggle same cycle starts ch0 only, sel=1, run_mask=001.
REQ-041 Ch0 values 01,02,03,04 sampled -> stash_count=3, stash_out 04; next_sample x3 -> 03,02,04.
REQ-042 reset asserted while ch0 in SPLIT and stash full -> all outputs at REQ-035 values next cycle.
